// File: rtl/prim_packer_arb_if.sv
// Beat-write bundle between NumReq narrow writers, the packer arbiter and the packer write port.
// The slave modport is the arbiter's view; master is the surrounding environment.
`timescale 1ns/1ps
interface prim_packer_arb_if #(
   parameter int NumReq = 3,
   parameter int InW    = 8
);
   logic [NumReq-1:0]     req_valid;
   logic [NumReq*InW-1:0] req_data;
   logic [NumReq-1:0]     req_ready;
   logic                  fifo_wvalid;
   logic [InW-1:0]        fifo_wdata;
   logic                  fifo_wready;

   modport slave (
      input  req_valid, req_data, fifo_wready,
      output req_ready, fifo_wvalid, fifo_wdata
   );

   modport master (
      output req_valid, req_data, fifo_wready,
      input  req_ready, fifo_wvalid, fifo_wdata
   );
endinterface

// File: rtl/prim_packer_arb.sv
// Round-robin writer lock for a pack-mode packer: one owner per OutW word, 1 grant bubble, ready follows packer wready.
// Stall timeout or clr_i sequences a 1-cycle packer clear; PRIM_PACKER_ARB_RID_EN adds rid_o/rid_valid_o word tags.
`timescale 1ns/1ps
module prim_packer_arb #(
   parameter int NumReq       = 3,
   parameter int InW          = 8,
   parameter int OutW         = 32,
   parameter int StallTimeout = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clr_i,
   prim_packer_arb_if.slave          bus,
   output logic                      fifo_clr_o,
   output logic                      err_o,
   output logic                      busy_o
`ifdef PRIM_PACKER_ARB_RID_EN
   ,
   output logic [$clog2(NumReq)-1:0] rid_o,
   output logic                      rid_valid_o
`endif
);
   localparam int Ratio = OutW / InW;
   localparam int BW    = $clog2(Ratio);
   localparam int OW    = $clog2(NumReq);
   localparam int SW    = (StallTimeout > 0) ? $clog2(StallTimeout + 1) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StLocked = 2'd1;
   localparam logic [1:0] StClear  = 2'd2;

   logic [1:0]    state_d, state_q;
   logic [OW-1:0] owner_d, owner_q;
   logic [OW-1:0] rr_ptr_d, rr_ptr_q;
   logic [BW-1:0] beat_cnt_d, beat_cnt_q;
   logic [SW-1:0] stall_cnt_d, stall_cnt_q;
   logic [OW-1:0] owner_inc;
   logic          accept;
   logic          found;
   int            j;
`ifdef PRIM_PACKER_ARB_RID_EN
   logic [OW-1:0] rid_d, rid_q;
   logic          rid_valid_d, rid_valid_q;
`endif

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      rr_ptr_d        = rr_ptr_q;
      beat_cnt_d      = beat_cnt_q;
      stall_cnt_d     = stall_cnt_q;
      bus.req_ready   = '0;
      bus.fifo_wvalid = 1'b0;
      bus.fifo_wdata  = '0;
      fifo_clr_o      = 1'b0;
      err_o           = 1'b0;
      accept          = 1'b0;
      found           = 1'b0;
      j               = 0;
      owner_inc       = (owner_q == OW'(NumReq - 1)) ? '0 : owner_q + OW'(1);
`ifdef PRIM_PACKER_ARB_RID_EN
      rid_d           = rid_q;
      rid_valid_d     = rid_valid_q;
`endif
      if (clr_i) begin
         // Clear wins over everything, including a timeout in the same cycle.
         fifo_clr_o = 1'b1;
         state_d    = StClear;
`ifdef PRIM_PACKER_ARB_RID_EN
         rid_valid_d = 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               for (int i = 0; i < NumReq; i++) begin
                  j = int'(rr_ptr_q) + i;
                  if (j >= NumReq) j = j - NumReq;
                  if (!found && bus.req_valid[j]) begin
                     found   = 1'b1;
                     owner_d = OW'(j);
                  end
               end
               if (found) state_d = StLocked;
            end
            StLocked: begin
               bus.fifo_wvalid        = bus.req_valid[owner_q];
               bus.fifo_wdata         = bus.req_data[owner_q*InW +: InW];
               bus.req_ready[owner_q] = bus.fifo_wready;
               accept                 = bus.req_valid[owner_q] && bus.fifo_wready;
               if (accept) begin
                  stall_cnt_d = '0;
                  if (beat_cnt_q == BW'(Ratio - 1)) begin
                     beat_cnt_d = '0;
                     rr_ptr_d   = owner_inc;
                     state_d    = StIdle;
`ifdef PRIM_PACKER_ARB_RID_EN
                     rid_d       = owner_q;
                     rid_valid_d = 1'b1;
`endif
                  end else begin
                     beat_cnt_d = beat_cnt_q + BW'(1);
                  end
               end else if (StallTimeout > 0 && beat_cnt_q != '0 && !bus.req_valid[owner_q]) begin
                  // Only a mid-word owner stall counts; packer back-pressure never does.
                  if (stall_cnt_q != SW'(StallTimeout)) stall_cnt_d = stall_cnt_q + SW'(1);
                  if (stall_cnt_d == SW'(StallTimeout)) begin
                     err_o    = 1'b1;
                     rr_ptr_d = owner_inc;
                     state_d  = StClear;
`ifdef PRIM_PACKER_ARB_RID_EN
                     rid_valid_d = 1'b0;
`endif
                  end
               end
            end
            StClear: begin
               fifo_clr_o  = 1'b1;
               beat_cnt_d  = '0;
               stall_cnt_d = '0;
               state_d     = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign busy_o = (state_q != StIdle);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef PRIM_PACKER_ARB_RID_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rid_q       <= '0;
         rid_valid_q <= 1'b0;
      end else begin
         rid_q       <= rid_d;
         rid_valid_q <= rid_valid_d;
      end
   end

   assign rid_o       = rid_q;
   assign rid_valid_o = rid_valid_q;
`endif

endmodule

// File: tb/tb_prim_packer_arb.sv
// Directed vector bench for prim_packer_arb; the packer write port is emulated by driving fifo_wready.
// Each vector is one clock: inputs driven 1ns after posedge, outputs sampled on the negedge.
`timescale 1ns/1ps
module tb_prim_packer_arb;
   localparam int NumReq       = 3;
   localparam int InW          = 8;
   localparam int OutW         = 32;
   localparam int StallTimeout = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   logic fifo_clr, err, busy;
`ifdef PRIM_PACKER_ARB_RID_EN
   logic [1:0] rid;
   logic       rid_valid;
`endif

   prim_packer_arb_if #(.NumReq(NumReq), .InW(InW)) bus ();

   prim_packer_arb #(
      .NumReq(NumReq), .InW(InW), .OutW(OutW), .StallTimeout(StallTimeout)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clr_i      (clr),
      .bus        (bus),
      .fifo_clr_o (fifo_clr),
      .err_o      (err),
      .busy_o     (busy)
`ifdef PRIM_PACKER_ARB_RID_EN
      ,
      .rid_o      (rid),
      .rid_valid_o(rid_valid)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        clr;
      logic [2:0]  vld;
      logic [23:0] dat;
      logic        wrdy;
      logic [2:0]  e_rdy;
      logic        e_wv;
      logic [7:0]  e_wd;
      logic        e_clr;
      logic        e_err;
      logic        e_busy;
      logic        chk_rid;
      logic [1:0]  e_rid;
      logic        e_ridv;
   } vec_t;

   vec_t tv[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic void add(input logic c, input logic [2:0] v, input logic [23:0] d,
                               input logic w, input logic [2:0] er, input logic ewv,
                               input logic [7:0] ewd, input logic ec, input logic ee,
                               input logic eb);
      vec_t t;
      t = '0;
      t.clr = c; t.vld = v; t.dat = d; t.wrdy = w;
      t.e_rdy = er; t.e_wv = ewv; t.e_wd = ewd; t.e_clr = ec; t.e_err = ee; t.e_busy = eb;
      tv.push_back(t);
   endfunction

   function automatic void idle(input logic [2:0] v, input logic [23:0] d);
      add(1'b0, v, d, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic void beat(input logic [2:0] v, input logic [23:0] d,
                                input logic [2:0] er, input logic [7:0] wd);
      add(1'b0, v, d, 1'b1, er, 1'b1, wd, 1'b0, 1'b0, 1'b1);
   endfunction

   // Attach a word-tag expectation to the most recently added vector.
   function automatic void rid_exp(input logic [1:0] r, input logic rv);
      vec_t t;
      t = tv.pop_back();
      t.chk_rid = 1'b1; t.e_rid = r; t.e_ridv = rv;
      tv.push_back(t);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s v%0d: got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      bus.req_valid   = '0;
      bus.req_data    = '0;
      bus.fifo_wready = 1'b0;

      // reset state
      idle(3'b000, 24'h0); rid_exp(2'd0, 1'b0);
      // req0 streams 11,22,33,44
      idle(3'b001, 24'h000011);
      beat(3'b001, 24'h000011, 3'b001, 8'h11);
      beat(3'b001, 24'h000022, 3'b001, 8'h22);
      beat(3'b001, 24'h000033, 3'b001, 8'h33);
      beat(3'b001, 24'h000044, 3'b001, 8'h44);
      idle(3'b000, 24'h0); rid_exp(2'd0, 1'b1);
      // all three valid: owners 1,2,0 from rr_ptr=1
      idle(3'b111, 24'hC2B1A0);
      for (int k = 0; k < 4; k++) beat(3'b111, 24'hC2B1A0, 3'b010, 8'hB1);
      idle(3'b111, 24'hC2B1A0); rid_exp(2'd1, 1'b1);
      for (int k = 0; k < 4; k++) beat(3'b111, 24'hC2B1A0, 3'b100, 8'hC2);
      idle(3'b111, 24'hC2B1A0); rid_exp(2'd2, 1'b1);
      for (int k = 0; k < 4; k++) beat(3'b111, 24'hC2B1A0, 3'b001, 8'hA0);
      idle(3'b000, 24'h0); rid_exp(2'd0, 1'b1);
      // packer back-pressure for 10 cycles mid-word: no timeout
      idle(3'b010, 24'h005500);
      beat(3'b010, 24'h005500, 3'b010, 8'h55);
      for (int k = 0; k < 10; k++)
         add(1'b0, 3'b010, 24'h005500, 1'b0, 3'b000, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) beat(3'b010, 24'h005500, 3'b010, 8'h55);
      idle(3'b000, 24'h0); rid_exp(2'd1, 1'b1);
      // req2 sends 2 beats then stalls 4 cycles: timeout on the 4th
      idle(3'b100, 24'h770000);
      beat(3'b100, 24'h770000, 3'b100, 8'h77);
      beat(3'b100, 24'h770000, 3'b100, 8'h77);
      for (int k = 0; k < 3; k++)
         add(1'b0, 3'b000, 24'h770000, 1'b1, 3'b100, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      add(1'b0, 3'b000, 24'h770000, 1'b1, 3'b100, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      add(1'b0, 3'b000, 24'h770000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      rid_exp(2'd1, 1'b0);
      // rr_ptr advanced to 0: req1 wins over req2, full 4 beats needed
      idle(3'b110, 24'h778800);
      for (int k = 0; k < 4; k++) beat(3'b110, 24'h778800, 3'b010, 8'h88);
      idle(3'b000, 24'h0); rid_exp(2'd1, 1'b1);
      // owner idles before its first beat: never times out
      idle(3'b100, 24'h990000);
      for (int k = 0; k < 6; k++)
         add(1'b0, 3'b000, 24'h990000, 1'b1, 3'b100, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) beat(3'b100, 24'h990000, 3'b100, 8'h99);
      idle(3'b000, 24'h0); rid_exp(2'd2, 1'b1);
      // clr_i on beat 3 of req0: beat dropped, req0 regranted, word restarts
      idle(3'b011, 24'h00665A);
      beat(3'b011, 24'h00665A, 3'b001, 8'h5A);
      beat(3'b011, 24'h00665A, 3'b001, 8'h5A);
      add(1'b1, 3'b011, 24'h00665A, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      add(1'b0, 3'b011, 24'h00665A, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      rid_exp(2'd2, 1'b0);
      idle(3'b011, 24'h00665A);
      for (int k = 0; k < 4; k++) beat(3'b011, 24'h00665A, 3'b001, 8'h5A);
      idle(3'b000, 24'h0); rid_exp(2'd0, 1'b1);
      // clr_i on the would-be timeout cycle: no err, rr_ptr unchanged
      idle(3'b010, 24'h4D3C00);
      beat(3'b010, 24'h4D3C00, 3'b010, 8'h3C);
      for (int k = 0; k < 3; k++)
         add(1'b0, 3'b000, 24'h4D3C00, 1'b1, 3'b010, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      add(1'b1, 3'b000, 24'h4D3C00, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      add(1'b0, 3'b000, 24'h4D3C00, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      rid_exp(2'd0, 1'b0);
      idle(3'b110, 24'h4D3C00);
      beat(3'b110, 24'h4D3C00, 3'b010, 8'h3C);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         @(posedge clk);
         #1;
         clr             = tv[i].clr;
         bus.req_valid   = tv[i].vld;
         bus.req_data    = tv[i].dat;
         bus.fifo_wready = tv[i].wrdy;
         @(negedge clk);
         chk("req_ready", i, 32'(bus.req_ready), 32'(tv[i].e_rdy));
         chk("fifo_wvalid", i, 32'(bus.fifo_wvalid), 32'(tv[i].e_wv));
         if (tv[i].e_wv) chk("fifo_wdata", i, 32'(bus.fifo_wdata), 32'(tv[i].e_wd));
         chk("fifo_clr", i, 32'(fifo_clr), 32'(tv[i].e_clr));
         chk("err", i, 32'(err), 32'(tv[i].e_err));
         chk("busy", i, 32'(busy), 32'(tv[i].e_busy));
`ifdef PRIM_PACKER_ARB_RID_EN
         if (tv[i].chk_rid) begin
            chk("rid", i, 32'(rid), 32'(tv[i].e_rid));
            chk("rid_valid", i, 32'(rid_valid), 32'(tv[i].e_ridv));
         end
`endif
      end

      // Async reset mid-word (owner 1 locked): immediate return to reset values, rr_ptr back to 0.
      @(posedge clk);
      #1;
      clr = 1'b0;
      bus.req_valid = 3'b011;
      bus.req_data  = 24'h00BBAA;
      bus.fifo_wready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", -1, 32'(busy), 32'd0);
      chk("rst_ready", -1, 32'(bus.req_ready), 32'd0);
      chk("rst_wvalid", -1, 32'(bus.fifo_wvalid), 32'd0);
`ifdef PRIM_PACKER_ARB_RID_EN
      chk("rst_rid_valid", -1, 32'(rid_valid), 32'd0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle_busy", -1, 32'(busy), 32'd0);
      chk("post_rst_idle_ready", -1, 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("post_rst_grant_ready", -1, 32'(bus.req_ready), 32'b001);
      chk("post_rst_grant_wdata", -1, 32'(bus.fifo_wdata), 32'hAA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
